sl_rx_scheduler: RTL and testbench

- Shares one downstream word stream, toward the APB-side buffer of the Sl-to-APB bridge, between NUM_CH serial-line receiver channels.
- Holds a per-channel configuration (enable, word-length mode) and drives each receiver's mode input.
- Picks among channels with a completed word using round-robin, acknowledges that receiver and right-justifies the word.
- Presents the word with a valid/ready handshake and keeps per-channel saturating word and error counters.

---
 rtl/sl_rx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_sl_rx_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_rx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sl_rx_scheduler
// Brief   : Round-robin scheduler sharing one word stream among NUM_CH serial
//           receivers, with per-channel config and saturating statistics.
// Revision: 1.0 - initial release
// ============================================================================
module sl_rx_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [32*NUM_CH-1:0]  ch_data,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [NUM_CH-1:0]     ch_perr,
    output logic [NUM_CH-1:0]     ch_ack,
    output logic [2*NUM_CH-1:0]   ch_mode,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_ch,
    input  logic                  cfg_en,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_clr,
    input  logic [2:0]            stat_ch,
    output logic [CNT_W-1:0]      stat_words,
    output logic [CNT_W-1:0]      stat_errs,
    output logic [31:0]           out_data,
    output logic [2:0]            out_ch,
    output logic [5:0]            out_len,
    output logic                  out_perr,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [NUM_CH-1:0]      en_q;
    logic [2*NUM_CH-1:0]    mode_q;
    logic [2:0]             ptr;
    logic [CNT_W-1:0]       words_q [NUM_CH];
    logic [CNT_W-1:0]       errs_q  [NUM_CH];

    logic [NUM_CH-1:0]      elig;
    logic [2:0]             pick;
    logic [NUM_CH-1:0]      pick_oh;
    logic [31:0]            sel_data;
    logic                   sel_perr;
    logic [1:0]             sel_mode;
    logic [31:0]            sel_aligned;
    logic [5:0]             sel_len;
    logic                   cfg_hit;
    logic                   grant;
    logic                   hs;

    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);
    assign elig    = en_q & ch_valid;
    assign ch_mode = mode_q;

    // Configuration registers; out-of-range channel writes fall through.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            mode_q <= '0;
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (cfg_hit && cfg_ch == 3'(j)) begin
                    en_q[j]          <= cfg_en;
                    mode_q[2*j +: 2] <= cfg_mode;
                end
            end
        end
    end

    // Pick the eligible channel with the smallest rotational distance from ptr.
    always_comb begin
        int best_d;
        int d;
        best_d = NUM_CH;
        d      = 0;
        pick   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            d = j - int'(ptr);
            if (d < 0) d = d + NUM_CH;
            if (elig[j] && d < best_d) begin
                best_d = d;
                pick   = 3'(j);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_perr = 1'b0;
        sel_mode = 2'b00;
        pick_oh  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (pick == 3'(j)) begin
                sel_data   = ch_data[32*j +: 32];
                sel_perr   = ch_perr[j];
                sel_mode   = mode_q[2*j +: 2];
                pick_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel_mode)
            2'b00:   begin sel_len = 6'd8;  sel_aligned = {24'b0, sel_data[31:24]}; end
            2'b01:   begin sel_len = 6'd16; sel_aligned = {16'b0, sel_data[31:16]}; end
            default: begin sel_len = 6'd32; sel_aligned = sel_data;                 end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        hs       = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    grant    = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    hs       = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_ack    <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_len   <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            ch_ack <= '0;
            if (grant) begin
                ch_ack    <= pick_oh;
                out_data  <= sel_aligned;
                out_ch    <= pick;
                out_len   <= sel_len;
                out_perr  <= sel_perr;
                out_valid <= 1'b1;
            end
            if (hs) begin
                out_valid <= 1'b0;
                ptr       <= (out_ch == 3'(NUM_CH - 1)) ? 3'd0 : out_ch + 3'd1;
            end
        end
    end

    // A clear on the same edge as a delivery leaves the counter at zero.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_CH; j++) begin
            if (reset || (cfg_hit && cfg_clr && cfg_ch == 3'(j))) begin
                words_q[j] <= '0;
                errs_q[j]  <= '0;
            end else if (hs && out_ch == 3'(j)) begin
                if (words_q[j] != '1)            words_q[j] <= words_q[j] + 1'b1;
                if (out_perr && errs_q[j] != '1) errs_q[j]  <= errs_q[j] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_words = '0;
        stat_errs  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (stat_ch == 3'(j)) begin
                stat_words = words_q[j];
                stat_errs  = errs_q[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sl_rx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_sl_rx_scheduler
// Brief   : Directed, table-driven self-checking bench for sl_rx_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sl_rx_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [32*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_perr;
    logic [NUM_CH-1:0]    ch_ack;
    logic [2*NUM_CH-1:0]  ch_mode;
    logic                 cfg_we;
    logic [2:0]           cfg_ch;
    logic                 cfg_en;
    logic [1:0]           cfg_mode;
    logic                 cfg_clr;
    logic [2:0]           stat_ch;
    logic [CNT_W-1:0]     stat_words;
    logic [CNT_W-1:0]     stat_errs;
    logic [31:0]          out_data;
    logic [2:0]           out_ch;
    logic [5:0]           out_len;
    logic                 out_perr;
    logic                 out_valid;
    logic                 out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sl_rx_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_perr(ch_perr),
        .ch_ack(ch_ack), .ch_mode(ch_mode),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
        .cfg_mode(cfg_mode), .cfg_clr(cfg_clr),
        .stat_ch(stat_ch), .stat_words(stat_words), .stat_errs(stat_errs),
        .out_data(out_data), .out_ch(out_ch), .out_len(out_len),
        .out_perr(out_perr), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        int          ch;
        logic [1:0]  mode;
        logic [31:0] data;
        logic        perr;
        logic [31:0] exp_data;
        logic [5:0]  exp_len;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic en, input logic [1:0] mode, input logic clr);
        cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_mode = mode; cfg_clr = clr;
        tick();
        cfg_we = 1'b0; cfg_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ch_valid = '0; ch_perr = '0; out_ready = 1'b0; cfg_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a word, checks it, then completes the handshake.
    task automatic expect_grant(input int ch, input logic [31:0] data, input logic [5:0] len,
                                input logic perr, input logic drop, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL grant_timeout ch%0d: out_valid=0 required 1", ch);
            return;
        end
        check("ack_onehot", 32'(ch_ack), 32'(1 << ch));
        check("out_ch",     32'(out_ch), 32'(ch));
        check("out_data",   out_data, data);
        check("out_len",    32'(out_len), 32'(len));
        check("out_perr",   32'(out_perr), 32'(perr));
        out_ready = 1'b1;
        if (drop) ch_valid[ch] = 1'b0;
        tick();
        out_ready = 1'b0;
        check("valid_after_hs", 32'(out_valid), 32'd0);
        check("ack_after_hs",   32'(ch_ack), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] held;
        int exp_w [NUM_CH];
        int exp_e [NUM_CH];

        vecs[0] = '{0, 2'b00, 32'hA5123456, 1'b0, 32'h000000A5, 6'd8};
        vecs[1] = '{1, 2'b01, 32'h1234ABCD, 1'b0, 32'h00001234, 6'd16};
        vecs[2] = '{2, 2'b10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 6'd32};
        vecs[3] = '{3, 2'b11, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 6'd32};
        vecs[4] = '{2, 2'b00, 32'h80FFFFFF, 1'b1, 32'h00000080, 6'd8};
        vecs[5] = '{0, 2'b01, 32'hFFFF0000, 1'b0, 32'h0000FFFF, 6'd16};
        exp_w = '{2, 1, 2, 1};
        exp_e = '{0, 0, 1, 1};

        reset = 1'b1; ch_data = '0; ch_valid = '0; ch_perr = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_mode = '0; cfg_clr = 1'b0;
        stat_ch = '0; out_ready = 1'b0;
        do_reset();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ch_ack",    32'(ch_ack), 32'd0);
        check("rst_ch_mode",   32'(ch_mode), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_stat",      32'(stat_words), 32'd0);

        // Out-of-range config write must not touch any channel.
        cfg(3'd4, 1'b1, 2'b01, 1'b0);
        check("cfg_oob_mode", 32'(ch_mode), 32'd0);
        ch_data[31:0] = 32'h11000000;
        ch_valid[0]   = 1'b1;
        tick();
        tick();
        check("disabled_no_grant", 32'(out_valid), 32'd0);
        check("disabled_no_ack",   32'(ch_ack), 32'd0);
        ch_valid = '0;

        for (int i = 0; i < 6; i++) begin
            cfg(3'(vecs[i].ch), 1'b1, vecs[i].mode, 1'b0);
            ch_data[32*vecs[i].ch +: 32] = vecs[i].data;
            ch_perr[vecs[i].ch]          = vecs[i].perr;
            ch_valid[vecs[i].ch]         = 1'b1;
            expect_grant(vecs[i].ch, vecs[i].exp_data, vecs[i].exp_len, vecs[i].perr, 1'b1, cyc);
            check("grant_latency", 32'(cyc), 32'd1);
            ch_perr = '0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            stat_ch = 3'(c);
            #1;
            check("tbl_words", 32'(stat_words), 32'(exp_w[c]));
            check("tbl_errs",  32'(stat_errs),  32'(exp_e[c]));
        end

        // Two requesters from pointer 0: ch1 then ch2.
        do_reset();
        cfg(3'd1, 1'b1, 2'b01, 1'b0);
        cfg(3'd2, 1'b1, 2'b10, 1'b0);
        ch_data[63:32] = 32'h1234FFFF;
        ch_data[95:64] = 32'hDEADBEEF;
        ch_valid = 4'b0110;
        expect_grant(1, 32'h00001234, 6'd16, 1'b0, 1'b1, cyc);
        expect_grant(2, 32'hDEADBEEF, 6'd32, 1'b0, 1'b1, cyc);
        check("pair_bubble", 32'(cyc), 32'd1);

        // All channels continuously valid: 0,1,2,3,0 with one bubble each.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            cfg(3'(c), 1'b1, 2'b10, 1'b0);
            ch_data[32*c +: 32] = 32'hC0DE0000 | c;
        end
        ch_valid = '1;
        for (int k = 0; k < 5; k++) begin
            expect_grant(k % NUM_CH, 32'hC0DE0000 | (k % NUM_CH), 6'd32, 1'b0, 1'b0, cyc);
            check("rr_rate", 32'(cyc), 32'd1);
        end
        ch_valid = '0;

        // Backpressure on ch3 with parity error; a mode change mid-hold is ignored.
        do_reset();
        cfg(3'd3, 1'b1, 2'b10, 1'b0);
        ch_data[127:96] = 32'h89ABCDEF;
        ch_perr[3]  = 1'b1;
        ch_valid[3] = 1'b1;
        tick();
        check("bp_ack",   32'(ch_ack), 32'h8);
        check("bp_valid", 32'(out_valid), 32'd1);
        held = out_data;
        cfg(3'd3, 1'b1, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_stable_data", out_data, held);
            check("bp_no_ack",      32'(ch_ack), 32'd0);
            check("bp_valid_hold",  32'(out_valid), 32'd1);
        end
        check("bp_len_kept", 32'(out_len), 32'd32);
        check("bp_data",     out_data, 32'h89ABCDEF);
        check("bp_perr",     32'(out_perr), 32'd1);
        out_ready = 1'b1; ch_valid[3] = 1'b0;
        tick();
        out_ready = 1'b0; ch_perr = '0;
        stat_ch = 3'd3;
        #1;
        check("bp_valid_done", 32'(out_valid), 32'd0);
        check("bp_stat_errs",  32'(stat_errs), 32'd1);
        check("bp_stat_words", 32'(stat_words), 32'd1);

        // Disabled ch0 is skipped, then served once enabled.
        cfg(3'd1, 1'b1, 2'b00, 1'b0);
        ch_data[31:0]  = 32'h5A000000;
        ch_data[63:32] = 32'h3C000000;
        ch_valid = 4'b0011;
        expect_grant(1, 32'h0000003C, 6'd8, 1'b0, 1'b1, cyc);
        check("dis_ch0_pending", 32'(ch_valid[0]), 32'd1);
        cfg(3'd0, 1'b1, 2'b00, 1'b0);
        expect_grant(0, 32'h0000005A, 6'd8, 1'b0, 1'b1, cyc);

        // Reset while holding a word.
        cfg(3'd2, 1'b1, 2'b01, 1'b0);
        ch_data[95:64] = 32'hBEEF0000;
        ch_valid[2] = 1'b1;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stat_ch = 3'd1;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_mode",  32'(ch_mode), 32'd0);
        check("hold_rst_stat",  32'(stat_words), 32'd0);
        tick();
        check("hold_rst_disabled", 32'(out_valid), 32'd0);
        ch_valid = '0;

        // Saturation, then clear coinciding with a delivery.
        cfg(3'd0, 1'b1, 2'b00, 1'b0);
        ch_data[31:0] = 32'hAB000000;
        ch_valid[0] = 1'b1;
        out_ready   = 1'b1;
        stat_ch     = 3'd0;
        repeat (2 * ((1 << CNT_W) + 3) + 2) tick();
        check("sat_words", 32'(stat_words), 32'hFF);
        check("sat_errs",  32'(stat_errs), 32'd0);
        if (!out_valid) tick();
        check("clr_in_hold", 32'(out_valid), 32'd1);
        cfg(3'd0, 1'b1, 2'b00, 1'b1);
        check("clr_wins", 32'(stat_words), 32'd0);
        tick();
        tick();
        check("after_clr_inc", 32'(stat_words), 32'd1);
        ch_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
